// File: rtl/dmem_pkg.sv
// Shared types for the data-memory access pipeline: request entry, FSM state
// and the bank chip-select decode.
package dmem_pkg;
    localparam int DM_ADDR_W = 12;
    localparam int DM_SUB_W  = 7;
    localparam int DM_NBANK  = 2 ** (DM_ADDR_W - DM_SUB_W);

    typedef struct packed {
        logic                 vld;
        logic                 rw;
        logic [DM_ADDR_W-1:0] addr;
    } req_t;

    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

    function automatic logic [DM_NBANK-1:0] bank_onehot(input logic [DM_ADDR_W-1:0] addr);
        logic [DM_NBANK-1:0] oh;
        oh = '0;
        oh[addr[DM_ADDR_W-1:DM_SUB_W]] = 1'b1;
        return oh;
    endfunction
endpackage

// File: rtl/dmem_dly_line.sv
// Destination delay line: shifts toward S[0] on each advance and inserts a new
// entry at the (clamped) delay slot, dropping it if that slot is already taken.
module dmem_dly_line
    import dmem_pkg::*;
#(
    parameter int MAX_DLY = 4,
    parameter int DLY_W   = $clog2(MAX_DLY)
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             adv,
    input  logic             ins,
    input  req_t             ins_req,
    input  logic [DLY_W-1:0] dly,
    output req_t             head,
    output logic             drop
);
    req_t s   [MAX_DLY];
    req_t nxt [MAX_DLY];
    int   slot;
    logic occ;

    always_comb begin
        slot = (int'(dly) >= MAX_DLY) ? MAX_DLY - 1 : int'(dly);
        // occupancy is judged after the shift: slot i then holds old S[i+1]
        occ = 1'b0;
        for (int i = 0; i < MAX_DLY - 1; i++)
            if (i == slot) occ = s[i+1].vld;
        for (int i = 0; i < MAX_DLY; i++) nxt[i] = '0;
        for (int i = 0; i < MAX_DLY - 1; i++) nxt[i] = s[i+1];
        for (int i = 0; i < MAX_DLY; i++)
            if (ins && !occ && i == slot) nxt[i] = ins_req;
        drop = ins && occ;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < MAX_DLY; i++) s[i] <= '0;
        end else if (adv) begin
            for (int i = 0; i < MAX_DLY; i++) s[i] <= nxt[i];
        end
    end

    assign head = s[0];
endmodule

// File: rtl/dmem_access_pipe.sv
// Data-memory access pipeline: source read stage, delayed destination line and
// a single-port arbiter that defers a colliding read by one cycle under stall.
module dmem_access_pipe
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = DM_ADDR_W,
    parameter int SUB_W   = DM_SUB_W,
    parameter int NBANK   = 2 ** (ADDR_W - SUB_W),
    parameter int MAX_DLY = 4,
    parameter int DLY_W   = $clog2(MAX_DLY)
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              t_cs,
    input  logic              src_en_b,
    input  logic              src_ind,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic              dst_en_b,
    input  logic              dst_rw,
    input  logic              dst_ind,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [DLY_W-1:0]  dly,
    input  logic [ADDR_W-1:0] ind_addr,
    output logic              dram_en_b,
    output logic              dram_rw,
    output logic [NBANK-1:0]  dram_cs,
    output logic [SUB_W-1:0]  dram_addr,
    output logic              stall,
    output logic              err
);
    state_t            state, state_n;
    req_t              rs, head, iss, dst_req;
    logic              adv, ins, drop;
    logic              issue, rs_load, rs_clr, err_set;
    logic [ADDR_W-1:0] src_a;

    assign adv     = t_cs && (state == IDLE);
    assign ins     = adv && !dst_en_b;
    assign src_a   = src_ind ? ind_addr : src_addr;
    assign dst_req = '{vld: 1'b1, rw: dst_rw, addr: (dst_ind ? ind_addr : dst_addr)};

    dmem_dly_line #(.MAX_DLY(MAX_DLY), .DLY_W(DLY_W)) u_dly (
        .clk     (clk),
        .reset_b (reset_b),
        .adv     (adv),
        .ins     (ins),
        .ins_req (dst_req),
        .dly     (dly),
        .head    (head),
        .drop    (drop)
    );

    always_comb begin
        state_n = state;
        issue   = 1'b0;
        iss     = '0;
        rs_load = 1'b0;
        rs_clr  = 1'b0;
        err_set = drop;
        case (state)
            IDLE: if (adv) begin
                // the write always wins the port so a same-address read sees new data
                if (head.vld) begin
                    issue = 1'b1;
                    iss   = head;
                    if (rs.vld) state_n = PEND;
                end else if (rs.vld) begin
                    issue  = 1'b1;
                    iss    = rs;
                    rs_clr = 1'b1;
                end
                if (!src_en_b) begin
                    if (head.vld && rs.vld) err_set = 1'b1;
                    else                    rs_load = 1'b1;
                end
            end
            PEND: begin
                issue   = 1'b1;
                iss     = rs;
                rs_clr  = 1'b1;
                state_n = IDLE;
                if (t_cs && (!src_en_b || !dst_en_b)) err_set = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state     <= IDLE;
            rs        <= '0;
            dram_en_b <= 1'b1;
            dram_rw   <= 1'b1;
            dram_cs   <= '0;
            dram_addr <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_n;
            err   <= err | err_set;
            if (rs_load)     rs     <= '{vld: 1'b1, rw: 1'b1, addr: src_a};
            else if (rs_clr) rs.vld <= 1'b0;
            if (issue) begin
                dram_en_b <= 1'b0;
                dram_rw   <= iss.rw;
                dram_addr <= iss.addr[SUB_W-1:0];
                dram_cs   <= bank_onehot(iss.addr);
            end else begin
                dram_en_b <= 1'b1;
                dram_rw   <= 1'b1;
            end
        end
    end

    assign stall = (state == PEND);
endmodule

// File: tb/tb_dmem_access_pipe.sv
// Scoreboarded bench: a departure-time reference model predicts every output
// cycle; directed cases also check fixed expected values.
module tb_dmem_access_pipe;
    localparam int MAXD = 4;

    logic        clk, reset_b, t_cs, src_en_b, src_ind, dst_en_b, dst_rw, dst_ind;
    logic [11:0] src_addr, dst_addr, ind_addr;
    logic [1:0]  dly;
    logic        dram_en_b, dram_rw, stall, err;
    logic [31:0] dram_cs;
    logic [6:0]  dram_addr;

    logic        b_reset_b, b_t_cs, b_src_en_b, b_src_ind, b_dst_en_b, b_dst_rw, b_dst_ind;
    logic [11:0] b_src_addr, b_dst_addr, b_ind_addr;
    logic [1:0]  b_dly;
    logic        b_dram_en_b, b_dram_rw, b_stall, b_err;
    logic [31:0] b_dram_cs;
    logic [6:0]  b_dram_addr;

    dmem_access_pipe dut (
        .clk(clk), .reset_b(reset_b), .t_cs(t_cs), .src_en_b(src_en_b), .src_ind(src_ind),
        .src_addr(src_addr), .dst_en_b(dst_en_b), .dst_rw(dst_rw), .dst_ind(dst_ind),
        .dst_addr(dst_addr), .dly(dly), .ind_addr(ind_addr), .dram_en_b(dram_en_b),
        .dram_rw(dram_rw), .dram_cs(dram_cs), .dram_addr(dram_addr), .stall(stall), .err(err)
    );

    dmem_access_pipe #(.MAX_DLY(2), .DLY_W(2)) dut_b (
        .clk(clk), .reset_b(b_reset_b), .t_cs(b_t_cs), .src_en_b(b_src_en_b), .src_ind(b_src_ind),
        .src_addr(b_src_addr), .dst_en_b(b_dst_en_b), .dst_rw(b_dst_rw), .dst_ind(b_dst_ind),
        .dst_addr(b_dst_addr), .dly(b_dly), .ind_addr(b_ind_addr), .dram_en_b(b_dram_en_b),
        .dram_rw(b_dram_rw), .dram_cs(b_dram_cs), .dram_addr(b_dram_addr), .stall(b_stall), .err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en_b;
        logic        rw;
        logic [6:0]  addr;
        logic [31:0] cs;
        logic        stall;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each queued write is keyed by the advance-edge count at
    // which it departs; frozen cycles simply do not bump the count.
    int          m_adv;
    logic        dq_rw[int];
    logic [11:0] dq_addr[int];
    logic        rs_v, m_pend, m_err, m_en_b, m_rw;
    logic [11:0] rs_a;
    logic [6:0]  m_addr;
    logic [31:0] m_cs;

    function automatic void model_reset();
        m_adv = 0; dq_rw.delete(); dq_addr.delete();
        rs_v = 0; rs_a = 0; m_pend = 0; m_err = 0;
        m_en_b = 1; m_rw = 1; m_addr = 0; m_cs = 0;
    endfunction

    function automatic void m_issue(input logic rw, input logic [11:0] a);
        m_en_b = 0; m_rw = rw; m_addr = a[6:0]; m_cs = 32'h1 << a[11:7];
    endfunction

    function automatic void model_step(input logic tc, se, si, input logic [11:0] sa,
                                       input logic de, drw, di, input logic [11:0] da,
                                       input logic [1:0] dl, input logic [11:0] ia);
        int d, t;
        m_en_b = 1; m_rw = 1;
        if (m_pend) begin
            m_issue(1'b1, rs_a); rs_v = 0; m_pend = 0;
            if (tc && (!se || !de)) m_err = 1;
        end else if (tc) begin
            m_adv++;
            if (dq_rw.exists(m_adv)) begin
                m_issue(dq_rw[m_adv], dq_addr[m_adv]);
                dq_rw.delete(m_adv); dq_addr.delete(m_adv);
                if (rs_v) m_pend = 1;
            end else if (rs_v) begin
                m_issue(1'b1, rs_a); rs_v = 0;
            end
            if (!se) begin
                if (m_pend) m_err = 1;
                else begin rs_v = 1; rs_a = si ? ia : sa; end
            end
            if (!de) begin
                d = (int'(dl) > MAXD - 1) ? MAXD - 1 : int'(dl);
                t = m_adv + d + 1;
                if (dq_rw.exists(t)) m_err = 1;
                else begin dq_rw[t] = drw; dq_addr[t] = di ? ia : da; end
            end
        end
        sbq.push_back('{m_en_b, m_rw, m_addr, m_cs, m_pend, m_err});
    endfunction

    task automatic drive(input logic tc, se, si, input logic [11:0] sa,
                         input logic de, drw, di, input logic [11:0] da,
                         input logic [1:0] dl, input logic [11:0] ia);
        @(negedge clk);
        reset_b = 1; t_cs = tc; src_en_b = se; src_ind = si; src_addr = sa;
        dst_en_b = de; dst_rw = drw; dst_ind = di; dst_addr = da; dly = dl; ind_addr = ia;
        model_step(tc, se, si, sa, de, drw, di, da, dl, ia);
    endtask

    task automatic idle(input int n, input logic tc);
        for (int i = 0; i < n; i++) drive(tc, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset_b = 0; t_cs = 1; src_en_b = 1; dst_en_b = 1;
            model_reset();
            sbq.push_back('{1'b1, 1'b1, 7'h0, 32'h0, 1'b0, 1'b0});
            if (i == 0) begin
                #1;
                cmp("rst_now_en_b", dram_en_b, 1); cmp("rst_now_rw", dram_rw, 1);
                cmp("rst_now_cs", dram_cs, 0);     cmp("rst_now_addr", dram_addr, 0);
                cmp("rst_now_stall", stall, 0);    cmp("rst_now_err", err, 0);
            end
        end
    endtask

    task automatic at_next();
        @(posedge clk); #2;
    endtask

    // monitor: one expected record per clock edge
    initial begin
        forever begin
            exp_t e;
            @(posedge clk); #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                cmp("sb_en_b", dram_en_b, e.en_b);
                cmp("sb_rw", dram_rw, e.rw);
                cmp("sb_stall", stall, e.stall);
                cmp("sb_err", err, e.err);
                if (!e.en_b) begin
                    cmp("sb_addr", dram_addr, e.addr);
                    cmp("sb_cs", dram_cs, e.cs);
                end else if (e.cs != 0) begin
                    cmp("sb_hold_addr", dram_addr, e.addr);
                    cmp("sb_hold_cs", dram_cs, e.cs);
                end
            end
        end
    end

    initial begin
        reset_b = 0; t_cs = 0; src_en_b = 1; src_ind = 0; src_addr = 0;
        dst_en_b = 1; dst_rw = 1; dst_ind = 0; dst_addr = 0; dly = 0; ind_addr = 0;
        b_reset_b = 0; b_t_cs = 0; b_src_en_b = 1; b_src_ind = 0; b_src_addr = 0;
        b_dst_en_b = 1; b_dst_rw = 1; b_dst_ind = 0; b_dst_addr = 0; b_dly = 0; b_ind_addr = 0;
        model_reset();

        // MAX_DLY=2 instance: indirect read plus a write whose dly=3 clamps to 1
        repeat (2) @(negedge clk);
        b_reset_b = 1;
        @(negedge clk);
        b_t_cs = 1; b_src_en_b = 0; b_src_ind = 1; b_ind_addr = 12'hFFF; b_src_addr = 12'h000;
        b_dst_en_b = 0; b_dst_rw = 0; b_dst_ind = 0; b_dst_addr = 12'h123; b_dly = 2'd3;
        @(negedge clk);
        b_src_en_b = 1; b_dst_en_b = 1;
        at_next();
        cmp("ind_en_b", b_dram_en_b, 0); cmp("ind_rw", b_dram_rw, 1);
        cmp("ind_addr", b_dram_addr, 7'h7F); cmp("ind_cs", b_dram_cs, 32'h8000_0000);
        at_next();
        cmp("clamp_en_b", b_dram_en_b, 0); cmp("clamp_rw", b_dram_rw, 0);
        cmp("clamp_addr", b_dram_addr, 7'h23); cmp("clamp_cs", b_dram_cs, 32'h4);
        cmp("clamp_err", b_err, 0);
        at_next();
        cmp("clamp_after_en_b", b_dram_en_b, 1);

        do_reset(2);

        // direct source read, constant advance
        drive(1, 0, 0, 12'h0A5, 1, 1, 0, 0, 0, 0);
        idle(1, 1);
        at_next();
        cmp("src_en_b", dram_en_b, 0); cmp("src_rw", dram_rw, 1);
        cmp("src_addr", dram_addr, 7'h25); cmp("src_cs", dram_cs, 32'h2);

        // delayed write with two frozen cycles midway
        idle(2, 1);
        drive(1, 1, 0, 0, 0, 0, 0, 12'h3FF, 2'd3, 0);
        idle(1, 1); idle(2, 0); idle(3, 1);
        at_next();
        cmp("dst_en_b", dram_en_b, 0); cmp("dst_rw", dram_rw, 0);
        cmp("dst_addr", dram_addr, 7'h7F); cmp("dst_cs", dram_cs, 32'h80);

        // write/read collision on the same address, plus request during stall
        do_reset(1);
        drive(1, 1, 0, 0, 0, 0, 0, 12'h155, 2'd1, 0);
        drive(1, 0, 0, 12'h155, 1, 1, 0, 0, 0, 0);
        idle(1, 1);
        at_next();
        cmp("col_w_en_b", dram_en_b, 0); cmp("col_w_rw", dram_rw, 0);
        cmp("col_w_stall", stall, 1);    cmp("col_w_err", err, 0);
        drive(1, 0, 0, 12'h200, 1, 1, 0, 0, 0, 0);
        at_next();
        cmp("col_r_en_b", dram_en_b, 0); cmp("col_r_rw", dram_rw, 1);
        cmp("col_r_stall", stall, 0);    cmp("col_r_err", err, 1);
        cmp("col_r_addr", dram_addr, 7'h55); cmp("col_r_cs", dram_cs, 32'h4);
        idle(3, 1);

        // two writes aimed at the same slot: second is dropped
        do_reset(1);
        drive(1, 1, 0, 0, 0, 0, 0, 12'h0C1, 2'd2, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 12'h7E2, 2'd1, 0);
        idle(1, 1);
        at_next();
        cmp("drop_err", err, 1); cmp("drop_early_en_b", dram_en_b, 1);
        idle(1, 1);
        at_next();
        cmp("drop_w_en_b", dram_en_b, 0); cmp("drop_w_addr", dram_addr, 7'h41);
        cmp("drop_w_cs", dram_cs, 32'h2);
        idle(3, 1);

        // reset with writes queued: nothing may issue after release
        do_reset(1);
        drive(1, 1, 0, 0, 0, 0, 0, 12'h111, 2'd3, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 12'h222, 2'd3, 0);
        drive(1, 0, 0, 12'h333, 0, 0, 0, 12'h444, 2'd2, 0);
        do_reset(3);
        idle(8, 1);

        // randomized traffic with a reset in the middle
        for (int i = 0; i < 800; i++) begin
            if (i == 400) do_reset(2);
            drive(($urandom_range(0, 9) < 8), 1'($urandom), 1'($urandom), 12'($urandom),
                  1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), 12'($urandom),
                  2'($urandom), 12'($urandom));
        end
        idle(6, 1);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
